// File: rtl/serial_paralelo_pkg.sv
// -----------------------------------------------------------------------------
// serial_paralelo_pkg
// Shared PHY receive-path definitions for the serial-to-parallel deserializer:
//   - COMMA        : K28.5 alignment / idle symbol (8'hBC)
//   - BIT_CNT_W    : width of the in-byte bit counter
//   - BIT_CNT_LAST : bit counter value at which a byte boundary occurs
//   - CMA_CNT_W    : width of the consecutive-comma counter (BC_COUNT <= 15)
//   - phy_state_e  : SEARCH / ALIGN / ACTIVE alignment state encoding
//   - is_comma()   : symbol classification helper
// -----------------------------------------------------------------------------
package serial_paralelo_pkg;

    localparam logic [7:0] COMMA = 8'hBC;

    localparam int BIT_CNT_W = 3;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = 3'd7;

    localparam int CMA_CNT_W = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } phy_state_e;

    // True when an 8-bit window holds the alignment symbol.
    function automatic logic is_comma(input logic [7:0] sym);
        return (sym == COMMA);
    endfunction

endpackage : serial_paralelo_pkg

// File: rtl/serial_paralelo_if.sv
// -----------------------------------------------------------------------------
// serial_paralelo_if
// Bundles the deserializer's serial input and byte-side outputs.
//   data_in               : serial bit, MSB of each byte first
//   data_serial_paralelo  : deserialized byte, held between byte boundaries
//   valid_serial_paralelo : 1 = payload byte, 0 = comma / idle
//   byte_stb              : one-cycle pulse when the byte outputs update
//   active                : lock achieved, sticky until reset
// Modports:
//   master : the serial source / byte consumer side
//   slave  : the deserializer itself
// -----------------------------------------------------------------------------
interface serial_paralelo_if;

    logic       data_in;
    logic [7:0] data_serial_paralelo;
    logic       valid_serial_paralelo;
    logic       byte_stb;
    logic       active;

    modport master (
        output data_in,
        input  data_serial_paralelo,
        input  valid_serial_paralelo,
        input  byte_stb,
        input  active
    );

    modport slave (
        input  data_in,
        output data_serial_paralelo,
        output valid_serial_paralelo,
        output byte_stb,
        output active
    );

endinterface : serial_paralelo_if

// File: rtl/serial_paralelo_comma_aligner.sv
// -----------------------------------------------------------------------------
// serial_paralelo_comma_aligner
// Bit-sliding comma search and byte alignment FSM.
//   SEARCH : every bit position is tested for the comma.
//   ALIGN  : a comma was found; only byte boundaries are tested, and
//            BC_COUNT consecutive aligned commas are needed to lock.
//   ACTIVE : locked; a boundary strobe is produced every 8 bits.
// Ports:
//   clk_32f       in   bit-rate clock
//   reset         in   synchronous, active-high
//   data_in       in   serial bit
//   aligned_byte  out  current 8-bit window {history, data_in} (combinational)
//   byte_boundary out  this edge closes a byte while ACTIVE (combinational)
//   lock_edge     out  this edge declares lock (combinational)
// -----------------------------------------------------------------------------
module serial_paralelo_comma_aligner
    import serial_paralelo_pkg::*;
#(
    parameter int unsigned BC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] aligned_byte,
    output logic       byte_boundary,
    output logic       lock_edge
);

    localparam logic [CMA_CNT_W-1:0] BC_COUNT_C = CMA_CNT_W'(BC_COUNT);

    // Only the seven most recent bits are needed: the eighth comes straight
    // from data_in so a byte is recognised on the edge its last bit arrives.
    logic [6:0]           hist_r;
    logic [6:0]           hist_nxt_s;
    logic [BIT_CNT_W-1:0] bit_cnt_r;
    logic [BIT_CNT_W-1:0] bit_cnt_nxt_s;
    logic [CMA_CNT_W-1:0] comma_cnt_r;
    logic [CMA_CNT_W-1:0] comma_cnt_nxt_s;
    phy_state_e           state_r;
    phy_state_e           state_nxt_s;
    logic [7:0]           word_s;
    logic                 lock_s;
    logic                 boundary_s;

    assign word_s = {hist_r, data_in};

    // State, shift history and counters register.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_r     <= SEARCH;
            hist_r      <= 7'd0;
            bit_cnt_r   <= 3'd0;
            comma_cnt_r <= 4'd0;
        end else begin
            state_r     <= state_nxt_s;
            hist_r      <= hist_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            comma_cnt_r <= comma_cnt_nxt_s;
        end
    end

    // Next-state, counter and strobe logic for the alignment FSM.
    always_comb begin
        state_nxt_s     = state_r;
        hist_nxt_s      = word_s[6:0];
        bit_cnt_nxt_s   = bit_cnt_r;
        comma_cnt_nxt_s = comma_cnt_r;
        lock_s          = 1'b0;
        boundary_s      = 1'b0;

        case (state_r)
            SEARCH: begin
                bit_cnt_nxt_s = 3'd0;
                if (is_comma(word_s)) begin
                    comma_cnt_nxt_s = 4'd1;
                    if (BC_COUNT_C == 4'd1) begin
                        state_nxt_s = ACTIVE;
                        lock_s      = 1'b1;
                    end else begin
                        state_nxt_s = ALIGN;
                    end
                end else begin
                    state_nxt_s = SEARCH;
                end
            end

            ALIGN: begin
                // Counter wraps 7 -> 0 so the next byte starts aligned.
                bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                if (bit_cnt_r == BIT_CNT_LAST) begin
                    if (is_comma(word_s)) begin
                        comma_cnt_nxt_s = comma_cnt_r + 4'd1;
                        if ((comma_cnt_r + 4'd1) == BC_COUNT_C) begin
                            state_nxt_s = ACTIVE;
                            lock_s      = 1'b1;
                        end else begin
                            state_nxt_s = ALIGN;
                        end
                    end else begin
                        // Alignment broken: resume bit-sliding.
                        comma_cnt_nxt_s = 4'd0;
                        bit_cnt_nxt_s   = 3'd0;
                        state_nxt_s     = SEARCH;
                    end
                end else begin
                    state_nxt_s = ALIGN;
                end
            end

            ACTIVE: begin
                // Lock is sticky; data content never changes the state here.
                bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                if (bit_cnt_r == BIT_CNT_LAST) begin
                    boundary_s = 1'b1;
                end else begin
                    boundary_s = 1'b0;
                end
            end

            default: begin
                state_nxt_s     = SEARCH;
                bit_cnt_nxt_s   = 3'd0;
                comma_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    assign aligned_byte  = word_s;
    assign byte_boundary = boundary_s;
    assign lock_edge     = lock_s;

endmodule : serial_paralelo_comma_aligner

// File: rtl/serial_paralelo.sv
// -----------------------------------------------------------------------------
// serial_paralelo
// Serial-to-parallel deserializer with K28.5 comma alignment for the PHY
// receive path. One serial bit per clk_32f edge; once locked, one byte is
// presented every 8 clocks to the downstream 8->32 demux.
// Ports:
//   clk_32f  in   bit-rate clock, rising edge
//   reset    in   synchronous, active-high
//   bus      serial_paralelo_if.slave
//            data_in (in), data_serial_paralelo, valid_serial_paralelo,
//            byte_stb, active (out, all registered)
// Parameters:
//   BC_COUNT consecutive aligned commas required to declare lock (1..15)
// -----------------------------------------------------------------------------
module serial_paralelo
    import serial_paralelo_pkg::*;
#(
    parameter int unsigned BC_COUNT = 4
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    serial_paralelo_if.slave     bus
);

    logic [7:0] aligned_byte_s;
    logic       byte_boundary_s;
    logic       lock_edge_s;

    logic [7:0] data_r;
    logic       valid_r;
    logic       stb_r;
    logic       active_r;

    serial_paralelo_comma_aligner #(
        .BC_COUNT (BC_COUNT)
    ) u_aligner (
        .clk_32f       (clk_32f),
        .reset         (reset),
        .data_in       (bus.data_in),
        .aligned_byte  (aligned_byte_s),
        .byte_boundary (byte_boundary_s),
        .lock_edge     (lock_edge_s)
    );

    // Byte output registers: update on the lock edge and on every locked
    // byte boundary, so the byte is visible right after its last bit edge.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            data_r   <= 8'd0;
            valid_r  <= 1'b0;
            stb_r    <= 1'b0;
            active_r <= 1'b0;
        end else if (lock_edge_s) begin
            // The locking window is itself a comma, hence not payload.
            data_r   <= COMMA;
            valid_r  <= 1'b0;
            stb_r    <= 1'b1;
            active_r <= 1'b1;
        end else if (byte_boundary_s) begin
            data_r   <= aligned_byte_s;
            valid_r  <= !is_comma(aligned_byte_s);
            stb_r    <= 1'b1;
            active_r <= active_r;
        end else begin
            data_r   <= data_r;
            valid_r  <= valid_r;
            stb_r    <= 1'b0;
            active_r <= active_r;
        end
    end

    assign bus.data_serial_paralelo  = data_r;
    assign bus.valid_serial_paralelo = valid_r;
    assign bus.byte_stb              = stb_r;
    assign bus.active                = active_r;

endmodule : serial_paralelo

// File: tb/tb_serial_paralelo.sv
// -----------------------------------------------------------------------------
// tb_serial_paralelo
// Scoreboard bench: every byte expected on the output is queued with its
// value, payload flag and the clock count at which its strobe must appear;
// a negedge monitor pops and compares on each byte_stb.
// -----------------------------------------------------------------------------
module tb_serial_paralelo;

    typedef struct packed {
        logic [7:0]  data;
        logic        valid;
        logic [31:0] cyc;
    } exp_t;

    logic clk_32f = 1'b0;
    logic reset;

    serial_paralelo_if sp_if();

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    serial_paralelo #(
        .BC_COUNT (4)
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (sp_if.slave)
    );

    always #5 clk_32f = ~clk_32f;

    // Edge counter used to time-stamp expected strobes.
    always @(posedge clk_32f) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        sp_if.data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    // Sends a byte MSB first; when expect_out is set, queues the output the
    // deserializer must show right after the byte's last bit edge.
    task automatic send_byte(input logic [7:0] b, input logic expect_out);
        exp_t e;
        if (expect_out) begin
            e.data  = b;
            e.valid = (b != 8'hBC);
            e.cyc   = 32'(cyc + 8);
            exp_q.push_back(e);
        end
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_data"},   32'(sp_if.data_serial_paralelo), 32'd0);
        check_eq({tag, "_valid"},  32'(sp_if.valid_serial_paralelo), 32'd0);
        check_eq({tag, "_stb"},    32'(sp_if.byte_stb), 32'd0);
        check_eq({tag, "_active"}, 32'(sp_if.active), 32'd0);
    endtask

    task automatic check_drained(input string tag);
        @(negedge clk_32f);
        #1;
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expectation.
    always @(negedge clk_32f) begin
        if (sp_if.byte_stb === 1'b1) begin
            check_eq("stb_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_eq("stb_data",  32'(sp_if.data_serial_paralelo), 32'(mon_e.data));
                check_eq("stb_valid", 32'(sp_if.valid_serial_paralelo), 32'(mon_e.valid));
                check_eq("stb_cycle", 32'(cyc), mon_e.cyc);
            end
        end
    end

    initial begin
        logic [7:0] payload [5];
        logic [7:0] pat;
        payload[0] = 8'hBC;
        payload[1] = 8'h12;
        payload[2] = 8'h34;
        payload[3] = 8'hBC;
        payload[4] = 8'hFF;

        // Reset with random serial data.
        reset         = 1'b1;
        sp_if.data_in = 1'b0;
        repeat (3) begin
            sp_if.data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            #1;
        end
        check_all_zero("reset");
        reset = 1'b0;
        repeat (5) send_bit(1'($urandom_range(0, 1)));
        check_eq("no_lock_idle", 32'(sp_if.active), 32'd0);

        // Lock after 3 leading bits; last one is 1 so no early comma window.
        send_bit(1'($urandom_range(0, 1)));
        send_bit(1'($urandom_range(0, 1)));
        send_bit(1'b1);
        repeat (3) send_byte(8'hBC, 1'b0);
        check_eq("active_pre_lock", 32'(sp_if.active), 32'd0);
        send_byte(8'hBC, 1'b1);
        check_eq("active_lock", 32'(sp_if.active), 32'd1);
        check_eq("lock_stb", 32'(sp_if.byte_stb), 32'd1);

        // Payload after lock.
        foreach (payload[i]) send_byte(payload[i], 1'b1);
        check_drained("payload_drain");
        check_eq("active_sticky", 32'(sp_if.active), 32'd1);

        // Comma pattern straddling a byte boundary is ignored.
        send_byte(8'h0B, 1'b1);
        send_byte(8'hC0, 1'b1);
        send_byte(8'hBC, 1'b1);
        check_drained("straddle_drain");

        // Reset in the middle of a payload byte.
        pat = 8'hA5;
        for (int i = 7; i >= 4; i--) send_bit(pat[i]);
        reset = 1'b1;
        send_bit(pat[3]);
        check_all_zero("mid_reset");
        reset = 1'b0;

        // Failed alignment: interrupted comma run, then a fresh run of 4.
        send_byte(8'hBC, 1'b0);
        send_byte(8'hBC, 1'b0);
        send_byte(8'h55, 1'b0);
        check_eq("active_after_55", 32'(sp_if.active), 32'd0);
        repeat (3) send_byte(8'hBC, 1'b0);
        check_eq("active_3_commas", 32'(sp_if.active), 32'd0);
        send_byte(8'hBC, 1'b1);
        check_eq("active_relock", 32'(sp_if.active), 32'd1);
        send_byte(8'h3C, 1'b1);
        check_eq("stb_before_reset", 32'(sp_if.byte_stb), 32'd1);

        // Reset on the edge following a strobe clears it.
        reset = 1'b1;
        send_bit(1'b0);
        check_all_zero("stb_reset");
        reset = 1'b0;
        check_eq("final_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_paralelo

// File: doc/serial_paralelo.md
Name: serial_paralelo

Overview:
- Serial-to-parallel deserializer with comma alignment for the PCIe-style physical layer receive path.
- Takes a 1-bit serial stream, finds byte alignment on the 0xBC comma (K28.5), and locks after BC_COUNT consecutive aligned commas.
- Emits bytes plus a valid flag to the 8->32 demux stage directly downstream.
- Single clock: one serial bit per clock; one byte boundary every 8 clocks.

Parameters:
- COMMA, 8'hBC, alignment/idle symbol.
- BC_COUNT, 4, consecutive aligned commas required to declare lock (range 1..15).

Ports:
- clk_32f  input  1  bit-rate clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial bit, MSB of each byte first.
- data_serial_paralelo  output  8  deserialized byte; held between byte boundaries.
- valid_serial_paralelo  output  1  byte is payload (1) or comma/idle (0); held between boundaries.
- byte_stb  output  1  one-cycle pulse on the edge data_serial_paralelo/valid_serial_paralelo update.
- active  output  1  lock achieved; sticky until reset.

Behaviour:
- Reset (reset=1 at edge): all outputs 0; state SEARCH; shift register 0; bit counter 0; comma counter 0. Reset overrides everything, including mid-byte or mid-lock.
- Let w = {shift[6:0], data_in}. The shift register loads w on every non-reset edge.
- SEARCH (bit-sliding):
  - If w==COMMA: bit counter <= 0, comma counter <= 1, go to ALIGN. If BC_COUNT==1, go directly to ACTIVE instead.
  - Otherwise stay in SEARCH.
  - Outputs stay 0; byte_stb=0.
- ALIGN:
  - Bit counter increments 0..7 and wraps.
  - At the edge where counter==7 (byte boundary), if w==COMMA: comma counter++. When the count reaches BC_COUNT, go to ACTIVE on that same edge.
  - At the boundary, if w!=COMMA: comma counter <= 0, go to SEARCH.
  - Sliding detection does not restart until SEARCH is re-entered.
  - Outputs stay 0.
- Entering ACTIVE: active <= 1 on the lock edge. data_serial_paralelo <= COMMA, valid_serial_paralelo <= 0, byte_stb <= 1 on that edge.
- ACTIVE, at each byte boundary (counter==7):
  - data_serial_paralelo <= w.
  - valid_serial_paralelo <= (w != COMMA).
  - byte_stb <= 1.
- ACTIVE, on all other edges: byte_stb <= 0 and byte outputs hold.
- Latency: the last bit of a byte is sampled on edge N; the outputs and byte_stb reflect that byte immediately after edge N (0 extra cycles). byte_stb is high for exactly 1 of every 8 cycles.
- ACTIVE is sticky; lock is not dropped on payload or on misaligned data. Only reset clears it.
- A COMMA pattern straddling a byte boundary while in ALIGN or ACTIVE is ignored.
- Reset asserted while byte_stb=1 clears byte_stb on that edge.

Decomposition:
- Shared PHY package holds:
  - constant COMMA=8'hBC;
  - state encoding SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2;
  - BIT_CNT_W=3.
- Natural sub-module: comma_aligner. It holds the shift register, bit counter, and SEARCH/ALIGN/ACTIVE FSM, and outputs a byte boundary strobe plus the aligned byte. The top adds the output registers and valid logic.

Test Plan:
- Reset: hold reset=1 for 3 cycles with random data_in -> all outputs 0; after release, active stays 0 until commas arrive.
- Lock: send 3 random bits, then 4x 0xBC MSB-first -> active=1 on the last bit edge of the 4th comma; data_serial_paralelo=0xBC, valid_serial_paralelo=0, byte_stb pulses once.
- Payload: after lock, send 0xBC, 0x12, 0x34, 0xBC, 0xFF -> strobes every 8 cycles. Byte outputs per strobe: (0xBC,0), (0x12,1), (0x34,1), (0xBC,0), (0xFF,1).
- Failed alignment: send 0xBC, 0xBC, 0x55, then 4x 0xBC -> no lock after 0x55; lock only after the final 4th comma.
- Straddling pattern: after lock, send 0x0B then 0xC0 (bit-level 0xBC across the boundary) -> outputs (0x0B,1), (0xC0,1); alignment unchanged.
- Reset mid-operation: assert reset at bit 4 of a payload byte -> next edge all outputs 0, active=0; relock requires BC_COUNT new commas.
